// File: rtl/adc_emu_tx.sv
// adc_emu_tx: ADC-side emulator for the 10-bit parallel capture link (sample clock, patterns, latency, OE gate).
// Define ADC_EMU_DITHER_EN to add LFSR dither on data bit0 in ramp and constant modes.
module adc_emu_tx #(
  parameter int CLK_DIV  = 5,
  parameter int PIPE_LAT = 5,
  parameter int SQ_HALF  = 8
) (
  input  logic        clk_50M,
  input  logic        rst_n,
  input  logic        en,
  input  logic [1:0]  mode,
  input  logic [9:0]  const_val,
  input  logic [11:0] ext_data,
  input  logic        oe_n,
  output logic        ad_clk,
  output logic [9:0]  ad_data,
  output logic        otr,
  output logic        data_oe
);

  localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int SQ_W  = (SQ_HALF > 1) ? $clog2(SQ_HALF) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_DIV / 2);
  localparam logic [SQ_W-1:0]  SQ_LAST  = SQ_W'(SQ_HALF - 1);

  localparam logic [1:0] MODE_RAMP   = 2'd0;
  localparam logic [1:0] MODE_CONST  = 2'd1;
  localparam logic [1:0] MODE_EXT    = 2'd2;
  localparam logic [1:0] MODE_SQUARE = 2'd3;

  // Clip a 12-bit unsigned sample into the 10-bit range; result is {otr, data}.
  function automatic logic [10:0] sat_ext(input logic [11:0] x);
    if (x > 12'd1023)
      return {1'b1, 10'h3FF};
    else
      return {1'b0, x[9:0]};
  endfunction

  logic [CNT_W-1:0] cnt;
  logic             rise_tick;
  logic             fall_tick;
  logic [9:0]       ramp;
  logic [SQ_W-1:0]  sq_cnt;
  logic             sq_lvl;
  logic             dith;
  logic [10:0]      sample;
  logic [10:0]      pipe_p [PIPE_LAT];

  assign rise_tick = en && (cnt == '0);
  assign fall_tick = en && (cnt == CNT_HALF);

  always_ff @(posedge clk_50M) begin
    if (!rst_n) begin
      cnt    <= '0;
      ad_clk <= 1'b0;
    end else if (!en) begin
      cnt    <= '0;
      ad_clk <= 1'b0;
    end else begin
      cnt    <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
      ad_clk <= (cnt < CNT_HALF);
    end
  end

  // Pattern state advances on every sample point whatever the selected mode.
  always_ff @(posedge clk_50M) begin
    if (!rst_n) begin
      ramp   <= '0;
      sq_cnt <= '0;
      sq_lvl <= 1'b0;
    end else if (rise_tick) begin
      ramp <= ramp + 10'd1;
      if (sq_cnt == SQ_LAST) begin
        sq_cnt <= '0;
        sq_lvl <= ~sq_lvl;
      end else begin
        sq_cnt <= sq_cnt + SQ_W'(1);
      end
    end
  end

`ifdef ADC_EMU_DITHER_EN
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  logic [15:0] lfsr;

  always_ff @(posedge clk_50M) begin
    if (!rst_n)
      lfsr <= 16'hACE1;
    else if (rise_tick)
      lfsr <= lfsr_step(lfsr);
  end

  assign dith = lfsr[0];
`else
  assign dith = 1'b0;
`endif

  always_comb begin
    sample = '0;
    case (mode)
      MODE_RAMP:   sample = {1'b0, ramp[9:1], ramp[0] ^ dith};
      MODE_CONST:  sample = {1'b0, const_val[9:1], const_val[0] ^ dith};
      MODE_EXT:    sample = sat_ext(ext_data);
      MODE_SQUARE: sample = {1'b0, {10{sq_lvl}}};
      default:     sample = '0;
    endcase
  end

  // Stage boundary: sample point -> PIPE_LAT-deep shift register, clocked by rise ticks.
  always_ff @(posedge clk_50M) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE_LAT; i++)
        pipe_p[i] <= '0;
    end else if (rise_tick) begin
      pipe_p[0] <= sample;
      for (int i = 1; i < PIPE_LAT; i++)
        pipe_p[i] <= pipe_p[i-1];
    end
  end

  // Stage boundary: last pipeline stage -> output pins on the fall tick, gated by oe_n.
  always_ff @(posedge clk_50M) begin
    if (!rst_n) begin
      ad_data <= '0;
      otr     <= 1'b0;
      data_oe <= 1'b0;
    end else begin
      data_oe <= ~oe_n;
      if (oe_n) begin
        ad_data <= '0;
        otr     <= 1'b0;
      end else if (fall_tick) begin
        {otr, ad_data} <= pipe_p[PIPE_LAT-1];
      end
    end
  end

endmodule

// File: tb/tb_adc_emu_tx.sv
// Self-checking bench for adc_emu_tx: sample-indexed reference model, vector table and corner sequences.
module tb_adc_emu_tx;

  localparam int CLK_DIV  = 5;
  localparam int PIPE_LAT = 5;
  localparam int SQ_HALF  = 8;
  localparam int HALF     = CLK_DIV / 2;
  localparam int HSZ      = 8192;

  logic        clk_50M = 1'b0;
  logic        rst_n;
  logic        en;
  logic [1:0]  mode;
  logic [9:0]  const_val;
  logic [11:0] ext_data;
  logic        oe_n;
  logic        ad_clk;
  logic [9:0]  ad_data;
  logic        otr;
  logic        data_oe;

  always #5 clk_50M = ~clk_50M;

  adc_emu_tx #(.CLK_DIV(CLK_DIV), .PIPE_LAT(PIPE_LAT), .SQ_HALF(SQ_HALF)) dut (
    .clk_50M   (clk_50M),
    .rst_n     (rst_n),
    .en        (en),
    .mode      (mode),
    .const_val (const_val),
    .ext_data  (ext_data),
    .oe_n      (oe_n),
    .ad_clk    (ad_clk),
    .ad_data   (ad_data),
    .otr       (otr),
    .data_oe   (data_oe)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: samples indexed by their ordinal since reset.
  int          ns;
  int          phase;
  logic [10:0] hist [HSZ];
  logic        m_clk;
  logic [9:0]  m_data;
  logic        m_otr;
  logic        m_oe;

  typedef struct {
    logic [11:0] ext;
    logic [9:0]  data;
    logic        otr;
  } ext_vec_t;

  ext_vec_t ext_tab [6];

  function automatic logic [10:0] gen(input logic [1:0] md, input logic [9:0] cv,
                                      input logic [11:0] ex, input int n);
    logic [9:0] r;
    case (md)
      2'd0: begin r = 10'(n % 1024); return {1'b0, r}; end
      2'd1: return {1'b0, cv};
      2'd2: begin
        if (int'(ex) > 1023) return {1'b1, 10'd1023};
        r = ex[9:0];
        return {1'b0, r};
      end
      default: return ((n / SQ_HALF) % 2 == 1) ? {1'b0, 10'd1023} : 11'd0;
    endcase
  endfunction

  task automatic model_step();
    logic rise, fall;
    logic [10:0] outv;
    if (!rst_n) begin
      ns = 0; phase = 0; m_clk = 1'b0; m_data = '0; m_otr = 1'b0; m_oe = 1'b0;
      return;
    end
    rise  = en && (phase == 0);
    fall  = en && (phase == HALF);
    m_clk = en && (phase < HALF);
    m_oe  = !oe_n;
    outv  = (ns >= PIPE_LAT) ? hist[(ns - PIPE_LAT) % HSZ] : 11'd0;
    if (oe_n) begin
      m_data = '0; m_otr = 1'b0;
    end else if (fall) begin
      {m_otr, m_data} = outv;
    end
    if (rise) begin
      hist[ns % HSZ] = gen(mode, const_val, ext_data, ns);
      ns++;
    end
    phase = en ? (phase + 1) % CLK_DIV : 0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk_50M);
    #1;
    check("cycle{clk,oe,otr,data}", {19'd0, ad_clk, data_oe, otr, ad_data},
          {19'd0, m_clk, m_oe, m_otr, m_data});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Expects a fresh reset just applied, with en=1, mode=0, oe_n=0 already driven.
  task automatic ramp_start_check();
    logic [9:0] clk_pat;
    clk_pat = '0;
    for (int k = 0; k < 34; k++) begin
      tick();
      if (k < 10) clk_pat[9-k] = ad_clk;
      if (k == 2)  check("oe_after_reset", {31'd0, data_oe}, 32'd1);
      if (k == 26) check("ramp_sample0", {22'd0, ad_data}, 32'd0);
      if (k == 27) check("ramp_sample1_latency", {22'd0, ad_data}, 32'd1);
      if (k == 32) check("ramp_sample2", {22'd0, ad_data}, 32'd2);
    end
    check("ad_clk_shape", {22'd0, clk_pat}, {22'd0, 10'b1100011000});
  endtask

  initial begin
    logic [9:0] v0, prev, cur;
    logic       wrap_seen, seen_change;
    int         run_len;

    ext_tab[0] = '{ext: 12'd500,  data: 10'd500,  otr: 1'b0};
    ext_tab[1] = '{ext: 12'd1024, data: 10'd1023, otr: 1'b1};
    ext_tab[2] = '{ext: 12'd4095, data: 10'd1023, otr: 1'b1};
    ext_tab[3] = '{ext: 12'd1023, data: 10'd1023, otr: 1'b0};
    ext_tab[4] = '{ext: 12'd0,    data: 10'd0,    otr: 1'b0};
    ext_tab[5] = '{ext: 12'd1,    data: 10'd1,    otr: 1'b0};

    rst_n = 1'b0; en = 1'b0; mode = 2'd0; const_val = '0; ext_data = '0; oe_n = 1'b0;
    run(2);
    check("reset_outputs", {19'd0, ad_clk, data_oe, otr, ad_data}, 32'd0);

    rst_n = 1'b1; en = 1'b1;
    ramp_start_check();

    // Ramp through the 1023 -> 0 wrap.
    wrap_seen = 1'b0;
    prev = ad_data;
    for (int i = 0; i < 1030 * CLK_DIV; i++) begin
      tick();
      if (prev == 10'd1023 && ad_data == 10'd0) wrap_seen = 1'b1;
      prev = ad_data;
    end
    check("ramp_wrap", {31'd0, wrap_seen}, 32'd1);

    // External mode vectors, each held long enough to flush the pipeline.
    mode = 2'd2;
    for (int i = 0; i < 6; i++) begin
      ext_data = ext_tab[i].ext;
      run((PIPE_LAT + 1) * CLK_DIV);
      check("ext_data", {22'd0, ad_data}, {22'd0, ext_tab[i].data});
      check("ext_otr", {31'd0, otr}, {31'd0, ext_tab[i].otr});
    end

    // Square: runs of SQ_HALF samples between level changes.
    mode = 2'd3;
    run((PIPE_LAT + 1) * CLK_DIV);
    seen_change = 1'b0;
    run_len = 0;
    prev = ad_data;
    for (int i = 0; i < 40; i++) begin
      run(CLK_DIV);
      cur = ad_data;
      if (cur != 10'd0 && cur != 10'd1023) check("square_level", {22'd0, cur}, 32'd0);
      if (cur == prev) run_len++;
      else begin
        if (seen_change) check("square_run_len", run_len, SQ_HALF);
        seen_change = 1'b1;
        run_len = 1;
      end
      prev = cur;
    end
    check("square_saw_changes", {31'd0, seen_change}, 32'd1);

    mode = 2'd1; const_val = 10'h155;
    run((PIPE_LAT + 1) * CLK_DIV);
    check("const_value", {22'd0, ad_data}, 32'h155);

    // Output-enable window during ramp: no stall in the underlying sequence.
    mode = 2'd0;
    run((PIPE_LAT + 1) * CLK_DIV);
    v0 = ad_data;
    oe_n = 1'b1;
    run(3 * CLK_DIV);
    check("oe_window_data_oe", {31'd0, data_oe}, 32'd0);
    check("oe_window_data", {22'd0, ad_data}, 32'd0);
    oe_n = 1'b0;
    run(2 * CLK_DIV);
    check("oe_resume_value", {22'd0, ad_data}, {22'd0, 10'(v0 + 10'd5)});

    // Pause at a sample-period boundary, then resume.
    for (int i = 0; i < CLK_DIV && phase != 0; i++) tick();
    check("pause_aligned", phase, 0);
    v0 = ad_data;
    en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("pause_clk_low", {31'd0, ad_clk}, 32'd0);
      check("pause_data_frozen", {22'd0, ad_data}, {22'd0, v0});
    end
    en = 1'b1;
    run(CLK_DIV);
    check("resume_next", {22'd0, ad_data}, {22'd0, 10'(v0 + 10'd1)});
    run(CLK_DIV);
    check("resume_next2", {22'd0, ad_data}, {22'd0, 10'(v0 + 10'd2)});

    // One-cycle reset mid-stream.
    run(7);
    rst_n = 1'b0;
    tick();
    check("midreset_outputs", {19'd0, ad_clk, data_oe, otr, ad_data}, 32'd0);
    rst_n = 1'b1;
    ramp_start_check();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 499) != 0);
      if ($urandom_range(0, 49) == 0) en = ~en;
      if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 59) == 0) oe_n = ~oe_n;
      if ($urandom_range(0, 29) == 0) const_val = 10'($urandom_range(0, 1023));
      if ($urandom_range(0, 4) == 0) begin
        case ($urandom_range(0, 3))
          0: ext_data = 12'd1023;
          1: ext_data = 12'd1024;
          default: ext_data = 12'($urandom_range(0, 4095));
        endcase
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
